// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory port: address map, access sizes,
// requester ownership and the response pipeline slot.
package dmem_pkg;

    localparam logic [31:0] DMEM_BASE        = 32'h1000_0000;
    localparam int unsigned DMEM_BYTES       = 131072;
    localparam logic [31:0] UART_TX_ADDR     = 32'h2000_0000;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
    } dmem_req_t;

    typedef struct packed {
        logic valid;
        logic owner;
        logic is_load;
        logic err;
    } rsp_slot_t;

endpackage

// File: rtl/dmem_access_check.sv
// Pure combinational range and alignment check for one DMEM access.
// Addresses below BASE are out of range; the offset subtraction never wraps into range.
module dmem_access_check import dmem_pkg::*; #(
    parameter logic [31:0] BASE  = DMEM_BASE,
    parameter int unsigned BYTES = DMEM_BYTES
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        ok
);

    logic [31:0] offset;
    logic        range_ok;
    logic        align_ok;

    always_comb begin
        offset   = addr - BASE;
        range_ok = (addr >= BASE) && (offset < BYTES);
        align_ok = 1'b1;
        case (size)
            SZ_BYTE: align_ok = 1'b1;
            SZ_HALF: align_ok = ~addr[0];
            default: align_ok = (addr[1:0] == 2'b00);
        endcase
        ok = range_ok && align_ok;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single DMEM port: core has priority unless debug has
// been refused STARVE_LIMIT cycles in a row; responses return to their owner 2 cycles after grant.
module dmem_arbiter #(
    parameter logic [31:0] DMEM_BASE    = dmem_pkg::DMEM_BASE,
    parameter int unsigned DMEM_BYTES   = dmem_pkg::DMEM_BYTES,
    parameter int unsigned STARVE_LIMIT = dmem_pkg::STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [1:0]  core_size,
    input  logic        core_signed,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [1:0]  dbg_size,
    input  logic        dbg_signed,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_load_size,
    output logic [1:0]  mem_store_size,
    output logic        mem_signed,
    input  logic [31:0] mem_rdata
);

    import dmem_pkg::*;

    localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt_reg;
    logic [7:0] starve_cnt_next;
    rsp_slot_t  stage1_reg;
    rsp_slot_t  stage2_reg;
    rsp_slot_t  slot_in;

    dmem_req_t  core_r;
    dmem_req_t  dbg_r;
    dmem_req_t  sel_r;
    logic       dbg_pri;
    logic       core_gnt_int;
    logic       dbg_gnt_int;
    logic       any_gnt;
    logic       acc_ok;

    assign core_r = '{we: core_we, addr: core_addr, wdata: core_wdata, size: core_size, sgn: core_signed};
    assign dbg_r  = '{we: dbg_we,  addr: dbg_addr,  wdata: dbg_wdata,  size: dbg_size,  sgn: dbg_signed};

    // Grants are suppressed while in reset so no access can slip out before the pipeline is live.
    assign dbg_pri      = (starve_cnt_reg >= LIMIT8);
    assign core_gnt_int = rst_n & core_req & ~(dbg_req & dbg_pri);
    assign dbg_gnt_int  = rst_n & dbg_req & (~core_req | dbg_pri);
    assign any_gnt      = core_gnt_int | dbg_gnt_int;
    assign core_gnt     = core_gnt_int;
    assign dbg_gnt      = dbg_gnt_int;

    assign sel_r = dbg_gnt_int ? dbg_r : core_r;

    dmem_access_check #(
        .BASE  (DMEM_BASE),
        .BYTES (DMEM_BYTES)
    ) u_check (
        .addr (sel_r.addr),
        .size (sel_r.size),
        .ok   (acc_ok)
    );

    assign mem_read       = any_gnt & acc_ok & ~sel_r.we;
    assign mem_write      = any_gnt & acc_ok &  sel_r.we;
    assign mem_addr       = sel_r.addr;
    assign mem_wdata      = sel_r.wdata;
    assign mem_load_size  = sel_r.size;
    assign mem_store_size = sel_r.size;
    assign mem_signed     = sel_r.sgn;

    always_comb begin
        slot_in = '0;
        if (any_gnt) begin
            slot_in.valid   = 1'b1;
            slot_in.owner   = dbg_gnt_int ? OWN_DBG : OWN_CORE;
            slot_in.is_load = ~sel_r.we;
            slot_in.err     = ~acc_ok;
        end
    end

    always_comb begin
        starve_cnt_next = '0;
        if (dbg_req && !dbg_gnt_int)
            starve_cnt_next = (starve_cnt_reg == 8'hFF) ? starve_cnt_reg : starve_cnt_reg + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_reg     <= '0;
            stage2_reg     <= '0;
            starve_cnt_reg <= '0;
        end else begin
            stage1_reg     <= slot_in;
            stage2_reg     <= stage1_reg;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Stage 2 lines up with the DMEM output register, so mem_rdata belongs to its slot.
    logic        port_rvalid [2];
    logic [31:0] port_rdata  [2];
    logic        port_err    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign port_rvalid[gi] = stage2_reg.valid && (stage2_reg.owner == 1'(gi));
        assign port_err[gi]    = port_rvalid[gi] && stage2_reg.err;
        assign port_rdata[gi]  = (port_rvalid[gi] && stage2_reg.is_load && !stage2_reg.err) ? mem_rdata : '0;
    end

    assign core_rvalid = port_rvalid[OWN_CORE];
    assign core_rdata  = port_rdata[OWN_CORE];
    assign core_err    = port_err[OWN_CORE];
    assign dbg_rvalid  = port_rvalid[OWN_DBG];
    assign dbg_rdata   = port_rdata[OWN_DBG];
    assign dbg_err     = port_err[OWN_DBG];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a DMEM model with 2-cycle read latency, a request-level reference
// model with a response queue, directed scenarios with literal expectations and random traffic.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned BYTES = 131072;
    localparam int          LIMIT = 8;
    localparam int          WORDS = BYTES / 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, core_signed;
    logic [31:0] core_addr, core_wdata;
    logic [1:0]  core_size;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we, dbg_signed;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [1:0]  dbg_size;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        mem_read, mem_write, mem_signed;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_load_size, mem_store_size;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_size(core_size), .core_signed(core_signed), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_size(dbg_size), .dbg_signed(dbg_signed), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_load_size(mem_load_size), .mem_store_size(mem_store_size), .mem_signed(mem_signed),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
        int sh;
        logic [31:0] v;
        if (sz == 2'b00) begin
            sh = 8 * int'(a % 4);
            v  = (w >> sh) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * int'((a / 2) % 2);
            v  = (w >> sh) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] a,
                                             input logic [31:0] d, input logic [1:0] sz);
        int sh;
        logic [31:0] m;
        if (sz == 2'b00) begin
            sh = 8 * int'(a % 4);
            m  = 32'h0000_00FF << sh;
        end else if (sz == 2'b01) begin
            sh = 16 * int'((a / 2) % 2);
            m  = 32'h0000_FFFF << sh;
        end else begin
            sh = 0;
            m  = 32'hFFFF_FFFF;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    function automatic bit acc_ok(input logic [31:0] a, input logic [1:0] sz);
        longint unsigned la;
        la = {32'd0, a};
        if (la < 64'(BASE) || la >= 64'(BASE) + 64'(BYTES)) return 1'b0;
        if (sz == 2'b01 && (a % 2) != 0) return 1'b0;
        if (sz[1] && (a % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'(WORDS - 1));
    endfunction

    // DMEM model: strobes captured mid-cycle, write and registered read at the edge, then an output register.
    logic [31:0] dm [WORDS];
    logic [31:0] rd_stage;
    initial begin
        logic        c_rd, c_wr, c_sg;
        logic [31:0] c_addr, c_wdata;
        logic [1:0]  c_lsz, c_ssz;
        for (int i = 0; i < WORDS; i++) dm[i] = init_word(i);
        rd_stage  = '0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            c_rd = mem_read;  c_wr = mem_write; c_sg = mem_signed;
            c_addr = mem_addr; c_wdata = mem_wdata;
            c_lsz = mem_load_size; c_ssz = mem_store_size;
            @(posedge clk);
            mem_rdata <= rd_stage;
            if (c_wr === 1'b1) dm[widx(c_addr)] = st_merge(dm[widx(c_addr)], c_addr, c_wdata, c_ssz);
            if (c_rd === 1'b1) rd_stage <= ld_ext(dm[widx(c_addr)], c_addr, c_lsz, c_sg);
        end
    end

    // Reference model: arbitration rule, access check, shadow memory and a queue of due responses.
    typedef struct {
        int          due;
        bit          owner;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] shadow [WORDS];
    int          cyc    = 0;
    int          starve = 0;

    initial begin
        rsp_t        e;
        bit          ecv, ece, edv, ede, ecg, edg, ok;
        logic [31:0] ecd, edd, a, wd, ld;
        logic [1:0]  sz;
        logic        we, sg;
        for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            ecv = 0; ece = 0; ecd = '0; edv = 0; ede = 0; edd = '0;
            if (rst_n !== 1'b1) rq.delete();
            else if (rq.size() > 0 && rq[0].due == cyc) begin
                e = rq.pop_front();
                if (e.owner) begin edv = 1; edd = e.data; ede = e.err; end
                else         begin ecv = 1; ecd = e.data; ece = e.err; end
                $display("cyc=%0d rsp owner=%s rdata=%08h err=%0d", cyc, e.owner ? "dbg" : "core", e.data, e.err);
            end
            chk("core_rvalid", 32'(core_rvalid), 32'(ecv));
            chk("core_rdata",  core_rdata,       ecd);
            chk("core_err",    32'(core_err),    32'(ece));
            chk("dbg_rvalid",  32'(dbg_rvalid),  32'(edv));
            chk("dbg_rdata",   dbg_rdata,        edd);
            chk("dbg_err",     32'(dbg_err),     32'(ede));
            if (rst_n !== 1'b1) begin
                starve = 0;
                chk("rst_core_gnt",  32'(core_gnt),  32'd0);
                chk("rst_dbg_gnt",   32'(dbg_gnt),   32'd0);
                chk("rst_mem_read",  32'(mem_read),  32'd0);
                chk("rst_mem_write", 32'(mem_write), 32'd0);
                continue;
            end
            edg = dbg_req && (!core_req || starve >= LIMIT);
            ecg = core_req && !edg;
            chk("core_gnt", 32'(core_gnt), 32'(ecg));
            chk("dbg_gnt",  32'(dbg_gnt),  32'(edg));
            if (edg) begin a = dbg_addr;  we = dbg_we;  wd = dbg_wdata;  sz = dbg_size;  sg = dbg_signed;  end
            else     begin a = core_addr; we = core_we; wd = core_wdata; sz = core_size; sg = core_signed; end
            ok = (ecg || edg) && acc_ok(a, sz);
            chk("mem_read",       32'(mem_read),       32'(ok && !we));
            chk("mem_write",      32'(mem_write),      32'(ok && we));
            chk("mem_addr",       mem_addr,            a);
            chk("mem_wdata",      mem_wdata,           wd);
            chk("mem_load_size",  32'(mem_load_size),  32'(sz));
            chk("mem_store_size", 32'(mem_store_size), 32'(sz));
            chk("mem_signed",     32'(mem_signed),     32'(sg));
            if (ecg || edg) begin
                ld = '0;
                if (ok && !we) ld = ld_ext(shadow[widx(a)], a, sz, sg);
                if (ok && we) shadow[widx(a)] = st_merge(shadow[widx(a)], a, wd, sz);
                rq.push_back('{due: cyc + 2, owner: edg, data: ld, err: !ok});
            end
            starve = (dbg_req && !edg) ? ((starve < 255) ? starve + 1 : 255) : 0;
        end
    end

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_size = '0; core_signed = 0;
        dbg_req  = 0; dbg_we  = 0; dbg_addr  = '0; dbg_wdata  = '0; dbg_size  = '0; dbg_signed  = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic sg);
        core_req = 1; core_we = we; core_addr = a; core_wdata = d; core_size = sz; core_signed = sg;
    endtask

    task automatic set_dbg(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic sg);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_size = sz; dbg_signed = sg;
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] sz);
        int unsigned r;
        logic [31:0] off;
        r   = $urandom_range(0, 99);
        off = 32'($urandom_range(0, 63));
        if (r < 70) begin
            if (sz[1])            off = off & 32'hFFFF_FFFC;
            else if (sz == 2'b01) off = off & 32'hFFFF_FFFE;
            return BASE + off;
        end
        if (r < 85) return BASE + off;
        case (r % 5)
            0:       return BASE - 32'd4;
            1:       return BASE + BYTES - 32'd4;
            2:       return BASE + BYTES;
            3:       return 32'hFFFF_FFFC;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic cg, dg;
        logic [1:0] sz;
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        chk("reset_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("reset_dbg_rvalid",  32'(dbg_rvalid),  32'd0);
        chk("reset_core_rdata",  core_rdata,       32'd0);
        step(); step();
        rst_n = 1'b1;

        // Core load word from preloaded DMEM
        set_core(0, 32'h1000_0010, 32'd0, SZ_WORD, 0);
        @(negedge clk);
        chk("lw_core_gnt", 32'(core_gnt), 32'd1);
        chk("lw_mem_read", 32'(mem_read), 32'd1);
        step(); idle();
        step();
        @(negedge clk);
        chk("lw_rvalid", 32'(core_rvalid), 32'd1);
        chk("lw_rdata",  core_rdata,       32'hDEAD_BEEF);
        chk("lw_err",    32'(core_err),    32'd0);

        // Both ports every cycle: debug wins once the refusal count reaches the limit
        step();
        set_core(0, BASE + 32'h40, 32'd0, SZ_WORD, 0);
        set_dbg(0, BASE + 32'h44, 32'd0, SZ_WORD, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("starve_gnt", {30'd0, core_gnt, dbg_gnt}, (k == LIMIT) ? 32'd1 : 32'd2);
            step();
        end
        idle();
        step(); step();

        // Store then load to the same address from the other port
        set_core(1, 32'h1000_0020, 32'h1234_5678, SZ_WORD, 0);
        step(); idle();
        set_dbg(0, 32'h1000_0020, 32'd0, SZ_WORD, 0);
        step(); idle();
        @(negedge clk);
        chk("raw_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("raw_core_rdata",  core_rdata,       32'd0);
        step();
        @(negedge clk);
        chk("raw_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("raw_dbg_rdata",  dbg_rdata,       32'h1234_5678);

        // Misaligned core half and out-of-range debug store
        step();
        set_core(0, 32'h1000_0003, 32'd0, SZ_HALF, 0);
        set_dbg(1, 32'h0FFF_FFFC, 32'hCAFE_F00D, SZ_WORD, 0);
        @(negedge clk);
        chk("err_core_gnt", 32'(core_gnt), 32'd1);
        chk("err_no_read",  32'(mem_read), 32'd0);
        step(); core_req = 0;
        @(negedge clk);
        chk("err_dbg_gnt",  32'(dbg_gnt),   32'd1);
        chk("err_no_write", 32'(mem_write), 32'd0);
        step(); dbg_req = 0;
        @(negedge clk);
        chk("err_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("err_core_err",    32'(core_err),    32'd1);
        chk("err_core_rdata",  core_rdata,       32'd0);
        step();
        @(negedge clk);
        chk("err_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("err_dbg_err",    32'(dbg_err),    32'd1);
        chk("err_dbg_rdata",  dbg_rdata,       32'd0);

        // Byte store of 0x80, then signed and unsigned byte loads
        step();
        set_core(1, BASE + 32'h31, 32'h0000_0080, SZ_BYTE, 0);
        step();
        set_core(0, BASE + 32'h31, 32'd0, SZ_BYTE, 1);
        step();
        set_core(0, BASE + 32'h31, 32'd0, SZ_BYTE, 0);
        step(); idle();
        @(negedge clk);
        chk("lb_signed", core_rdata, 32'hFFFF_FF80);
        step();
        @(negedge clk);
        chk("lb_unsigned", core_rdata, 32'h0000_0080);

        // Reset in the cycle after a grant drops the in-flight response
        step();
        set_core(0, 32'h1000_0010, 32'd0, SZ_WORD, 0);
        step(); idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_gnt",    32'(core_gnt),    32'd0);
        chk("rst_rvalid", 32'(core_rvalid), 32'd0);
        step();
        @(negedge clk);
        chk("rst_dropped", 32'(core_rvalid), 32'd0);
        step();
        rst_n = 1'b1;
        set_core(0, 32'h1000_0010, 32'd0, SZ_WORD, 0);
        @(negedge clk);
        chk("post_rst_gnt", 32'(core_gnt), 32'd1);
        step(); idle();
        step();
        @(negedge clk);
        chk("post_rst_rdata", core_rdata, 32'hDEAD_BEEF);

        // Random traffic; a refused requester usually holds its request
        step();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            cg = core_gnt;
            dg = dbg_gnt;
            step();
            if (!(core_req && !cg && $urandom_range(0, 3) != 0)) begin
                if ($urandom_range(0, 99) < 65) begin
                    sz = 2'($urandom_range(0, 3));
                    set_core(1'($urandom_range(0, 1)), rand_addr(sz), $urandom(), sz, 1'($urandom_range(0, 1)));
                end else begin
                    core_req = 0;
                end
            end
            if (!(dbg_req && !dg && $urandom_range(0, 3) != 0)) begin
                if ($urandom_range(0, 99) < 45) begin
                    sz = 2'($urandom_range(0, 3));
                    set_dbg(1'($urandom_range(0, 1)), rand_addr(sz), $urandom(), sz, 1'($urandom_range(0, 1)));
                end else begin
                    dbg_req = 0;
                end
            end
        end
        idle();
        repeat (4) step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single data-memory port of the pipelined core.
- Shares DMEM between the core load/store port (MEM stage) and the debug/loader port.
- Checks range and alignment before an access reaches DMEM, issues at most one access per cycle, and returns each response to its owner in order, 2 cycles after grant.
- The 2-cycle response slot matches the 1-cycle registered-read latency plus the output register of the DMEM.

Parameters:
- DMEM_BASE, 32'h1000_0000, byte address of DMEM word 0.
- DMEM_BYTES, 131072, DMEM size in bytes.
- STARVE_LIMIT, 8, consecutive cycles dbg_req may be refused before debug gets priority (range 1..255).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  core access request.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data.
- core_size  in  2  00 byte, 01 half, 10/11 word.
- core_signed  in  1  signed load.
- core_gnt  out  1  request accepted this cycle (combinational); low = core stalls.
- core_rvalid  out  1  response for core.
- core_rdata  out  32  load data; 0 for stores and errors.
- core_err  out  1  qualifies core_rvalid; range or alignment fault.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size, dbg_signed, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err  same widths and meanings as the core_* ports, for the debug/loader port.
- mem_read  out  1  DMEM load strobe.
- mem_write  out  1  DMEM store strobe.
- mem_addr  out  32  DMEM address.
- mem_wdata  out  32  DMEM store data.
- mem_load_size  out  2  DMEM load size.
- mem_store_size  out  2  DMEM store size.
- mem_signed  out  1  DMEM signed load.
- mem_rdata  in  32  DMEM read data, valid 2 cycles after mem_read.

Behaviour:
- Reset (async, rst_n=0):
  - All registered state cleared: response pipeline valids, owner bits, starvation counter.
  - core_rvalid, dbg_rvalid, core_err, dbg_err = 0; core_rdata, dbg_rdata = 0.
  - In-flight responses are dropped, never delivered.
  - mem_read/mem_write are forced 0 while rst_n=0.
- Arbitration, evaluated combinationally each cycle:
  - Default priority is core.
  - Debug wins if starve_cnt >= STARVE_LIMIT.
  - Exactly one gnt is high when any req is high; both gnt are 0 when no req.
- Starvation counter (8-bit, saturating):
  - Increments when dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or when dbg_req=0.
- Access check on the granted request:
  - ok = addr in [DMEM_BASE, DMEM_BASE+DMEM_BYTES); half access requires addr[0]=0; word access requires addr[1:0]=00.
  - ok: drive mem_read = !we or mem_write = we in the grant cycle (cycle T). mem_addr, mem_wdata and the size fields mirror the granted requester; mem_load_size and mem_store_size both carry its size.
  - not ok: no DMEM strobe. The request is still granted and consumes its response slot.
  - When no grant, mem_* strobes are 0 and the data fields hold the core port's values.
- Response pipeline: 2 stages, each holding {valid, owner, is_load, err}.
  - Stage 1 loads at the end of T; stage 2 at the end of T+1.
  - In T+2 the owner's rvalid=1 with rdata = is_load & !err ? mem_rdata : 0, and err as recorded.
  - Stores and errored accesses also produce exactly one rvalid.
  - Back-to-back grants every cycle are supported: throughput 1 access/cycle, responses strictly in grant order.
- rdata/err/rvalid of a port are 0 in any cycle that port has no response; outputs are combinational from stage 2.
- Read-after-write: a store granted in T followed by a load to the same address in T+1 returns the new data (DMEM write completes at end of T).
- Simultaneous requests: the loser keeps its request asserted and stable until granted. A change of the loser's request before grant is legal and simply re-arbitrated.
- Address offset arithmetic is 32-bit unsigned; addr < DMEM_BASE is out of range and does not wrap.

Decomposition:
- Shared package dmem_pkg:
  - DMEM_BASE, DMEM_BYTES, UART_TX_ADDR constants.
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - Owner encoding OWN_CORE=0, OWN_DBG=1.
- One natural sub-module, dmem_access_check: pure combinational range and alignment check, reused by the MEM-stage assertions.

Test Plan:
- Core-only load word 0x1000_0010 (DMEM preloaded 0xDEADBEEF) -> core_gnt=1 in T, mem_read=1 in T, core_rvalid=1 with core_rdata=0xDEADBEEF and core_err=0 in T+2.
- Both ports request every cycle with STARVE_LIMIT=8 -> core granted T..T+7, dbg granted T+8; counter clears; core granted T+9.
- Core SW 0x1234_5678 to 0x1000_0020 in T, dbg LW 0x1000_0020 in T+1 -> core_rvalid (rdata=0) at T+2; dbg_rvalid with rdata=0x1234_5678 at T+3.
- Core LH at 0x1000_0003 and debug SW at 0x0FFF_FFFC -> no mem strobes; each err=1 with rvalid 2 cycles after its grant; rdata=0.
- Signed LB of byte 0x80 -> rdata=0xFFFF_FF80; unsigned LB -> 0x0000_0080.
- rst_n dropped at T+1 after a grant in T -> no rvalid at T+2; all outputs 0 during reset; first grant after release behaves normally.
